// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: ALU opcode, arbiter state and flag index definitions shared by the arbiter and its clients.
package alu_arb_pkg;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_MVN} alu_op_e;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_arbiter_rr_grant.sv
// rr_grant: combinational one-hot grant; round-robin after ptr, or lowest-index-wins when ALU_ARB_FIXED_PRIO_EN is defined.
module rr_grant #(
  parameter int N_REQ = 2,
  parameter int ID_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);
`ifdef ALU_ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr;
  // Scan downwards so the lowest valid index is the last one written.
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[i]) begin
        gnt = '0;
        gnt[i] = 1'b1;
        gnt_id = ID_W'(i);
      end
  end
`else
  logic [ID_W-1:0] w_idx;
  // Scan from farthest to nearest after ptr so the nearest valid requester wins.
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    w_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (req[w_idx]) begin
        gnt = '0;
        gnt[w_idx] = 1'b1;
        gnt_id = w_idx;
      end
    end
  end
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 16-bit ALU between N_REQ requesters with a tagged valid/ready response.
// ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [16*N_REQ-1:0] req_ain,
  input  logic [16*N_REQ-1:0] req_bin,
  input  logic [2*N_REQ-1:0]  req_op,
  output logic [15:0]         alu_ain,
  output logic [15:0]         alu_bin,
  output logic [1:0]          alu_op,
  input  logic [15:0]         alu_out,
  input  logic [2:0]          alu_z,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [15:0]         rsp_out,
  output logic [2:0]          rsp_flags
);
  arb_state_e      r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  logic [15:0]     r_ain;
  logic [15:0]     r_bin;
  alu_op_e         r_op;
  logic            r_valid;
  logic [15:0]     r_out;
  logic [2:0]      r_flags;
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_accept;

  rr_grant #(.N_REQ(N_REQ), .ID_W(ID_W)) u_grant (
    .req(req_valid),
    .ptr(r_ptr),
    .gnt(w_gnt),
    .gnt_id(w_gnt_id)
  );

  assign req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign w_accept  = (r_state == IDLE) && |w_gnt;
  assign alu_ain   = r_ain;
  assign alu_bin   = r_bin;
  assign alu_op    = r_op;
  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_out   = r_out;
  assign rsp_flags = r_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= ID_W'(N_REQ - 1);
      r_id    <= '0;
      r_ain   <= '0;
      r_bin   <= '0;
      r_op    <= ALU_ADD;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_flags <= '0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_ain   <= req_ain[16*w_gnt_id +: 16];
        r_bin   <= req_bin[16*w_gnt_id +: 16];
        r_op    <= alu_op_e'(req_op[2*w_gnt_id +: 2]);
        r_id    <= w_gnt_id;
        r_ptr   <= w_gnt_id;
        r_state <= EXEC;
      end
    end else if (r_state == EXEC) begin
      r_out   <= alu_out;
      r_flags <= alu_z;
      r_valid <= 1'b1;
      r_state <= RESP;
    end else if (rsp_ready) begin
      r_valid <= 1'b0;
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench with a behavioural ALU on the alu_* port.
module tb_alu_arbiter;
  import alu_arb_pkg::*;
  logic        clk = 0;
  logic        reset = 1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_ain = '0;
  logic [31:0] req_bin = '0;
  logic [3:0]  req_op = '0;
  logic [15:0] alu_ain, alu_bin, alu_out;
  logic [1:0]  alu_op;
  logic [2:0]  alu_z;
  logic        rsp_valid;
  logic        rsp_ready = 0;
  logic        rsp_id;
  logic [15:0] rsp_out;
  logic [2:0]  rsp_flags;
  logic [15:0] sum;
  int n_chk = 0;
  int n_err = 0;

  alu_arbiter #(.N_REQ(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ain(req_ain), .req_bin(req_bin), .req_op(req_op),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  always_comb begin
    sum = alu_ain + alu_bin;
    alu_out = (alu_op == 2'b00) ? sum :
              (alu_op == 2'b01) ? alu_ain - alu_bin :
              (alu_op == 2'b10) ? alu_ain & alu_bin : ~alu_bin;
    alu_z = '0;
    alu_z[FLAG_Z] = (alu_out == 16'h0);
    alu_z[FLAG_N] = alu_out[15];
    alu_z[FLAG_V] = (alu_ain[15] == alu_bin[15]) && (sum[15] != alu_ain[15]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    req_valid[i] = v;
    req_ain[16*i +: 16] = a;
    req_bin[16*i +: 16] = b;
    req_op[2*i +: 2] = op;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!rsp_valid && n < 8) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic single(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input logic [15:0] eo, input logic [2:0] ef, input string tag);
    drive(i, 1'b1, a, b, op);
    tick();
    drive(i, 1'b0, a, b, op);
    wait_valid({tag, "_valid"});
    chk({tag, "_id"}, {31'b0, rsp_id}, i);
    chk({tag, "_out"}, {16'b0, rsp_out}, {16'b0, eo});
    chk({tag, "_flags"}, {29'b0, rsp_flags}, {29'b0, ef});
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask

  initial begin
    int e;
    tick();
    tick();
    reset = 0;
    tick();
    chk("rst_valid", {31'b0, rsp_valid}, 0);
    chk("rst_ready", {30'b0, req_ready}, 0);
    chk("rst_ain", {16'b0, alu_ain}, 0);
    chk("rst_out", {16'b0, rsp_out}, 0);
    // single ADD with exact latency
    drive(0, 1'b1, 16'h0003, 16'h0004, ALU_ADD);
    #1;
    chk("t1_ready", {30'b0, req_ready}, 32'b01);
    tick();
    drive(0, 1'b0, 16'h0003, 16'h0004, ALU_ADD);
    chk("t1_exec_ready", {30'b0, req_ready}, 0);
    chk("t1_exec_valid", {31'b0, rsp_valid}, 0);
    chk("t1_alu_ain", {16'b0, alu_ain}, 32'h3);
    chk("t1_alu_bin", {16'b0, alu_bin}, 32'h4);
    tick();
    chk("t1_valid", {31'b0, rsp_valid}, 1);
    chk("t1_id", {31'b0, rsp_id}, 0);
    chk("t1_out", {16'b0, rsp_out}, 32'h7);
    chk("t1_flags", {29'b0, rsp_flags}, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("t1_done", {31'b0, rsp_valid}, 0);
    // both requesters continuously valid
    reset = 1;
    tick();
    reset = 0;
    rsp_ready = 1;
    drive(0, 1'b1, 16'h0001, 16'h0002, ALU_ADD);
    drive(1, 1'b1, 16'h0005, 16'h0005, ALU_SUB);
    for (int k = 0; k < 4; k++) begin
      wait_valid("t2_valid");
`ifdef ALU_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = k % 2;
`endif
      chk("t2_id", {31'b0, rsp_id}, e);
      chk("t2_out", {16'b0, rsp_out}, (e == 0) ? 32'h3 : 32'h0);
      chk("t2_flags", {29'b0, rsp_flags}, (e == 0) ? 32'b000 : 32'b100);
      tick();
    end
    req_valid = '0;
    rsp_ready = 0;
    // backpressure hold, then overflow ADD from req1
    drive(0, 1'b1, 16'h1234, 16'h0001, ALU_ADD);
    tick();
    drive(0, 1'b0, 16'h1234, 16'h0001, ALU_ADD);
    drive(1, 1'b1, 16'h7FFF, 16'h0001, ALU_ADD);
    wait_valid("t3_valid");
    chk("t3_id", {31'b0, rsp_id}, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_valid", {31'b0, rsp_valid}, 1);
      chk("t3_hold_out", {16'b0, rsp_out}, 32'h1235);
      chk("t3_hold_ready", {30'b0, req_ready}, 0);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("t3_released", {31'b0, rsp_valid}, 0);
    chk("t3_resume_ready", {30'b0, req_ready}, 32'b10);
    tick();
    drive(1, 1'b0, 16'h7FFF, 16'h0001, ALU_ADD);
    chk("t4_alu_ain", {16'b0, alu_ain}, 32'h7FFF);
    wait_valid("t4_valid");
    chk("t4_id", {31'b0, rsp_id}, 1);
    chk("t4_out", {16'b0, rsp_out}, 32'h8000);
    chk("t4_flags", {29'b0, rsp_flags}, 32'b011);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    single(0, 16'h0000, 16'h0000, ALU_MVN, 16'hFFFF, 3'b010, "t4_mvn");
    // reset while in EXEC discards the transaction
    drive(0, 1'b1, 16'h0009, 16'h0009, ALU_ADD);
    tick();
    drive(0, 1'b0, 16'h0009, 16'h0009, ALU_ADD);
    reset = 1;
    tick();
    reset = 0;
    chk("t5_valid", {31'b0, rsp_valid}, 0);
    chk("t5_ain", {16'b0, alu_ain}, 0);
    chk("t5_bin", {16'b0, alu_bin}, 0);
    chk("t5_op", {30'b0, alu_op}, 0);
    chk("t5_out", {16'b0, rsp_out}, 0);
    chk("t5_flags", {29'b0, rsp_flags}, 0);
    chk("t5_id", {31'b0, rsp_id}, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_no_rsp", {31'b0, rsp_valid}, 0);
    end
    single(1, 16'hF0F0, 16'h0FF0, ALU_AND, 16'h00F0, 3'b000, "t5_req1");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
